// File: rtl/period_count_if.sv
// Signal bundle between a measured source and period_count.
//   PWRDWN        : synchronous power-down request (to DUT)
//   meas_in       : signal under measurement, asynchronous (to DUT)
//   period_length : last measured period in clk cycles, 0 = none (from DUT)
//   high_length   : high time of the last measured period (from DUT)
//   period_valid  : one-cycle pulse on a new measurement (from DUT)
//   timeout       : sticky "no edge seen for TIMEOUT cycles" flag (from DUT)
interface period_count_if;
   logic        PWRDWN;
   logic        meas_in;
   logic [31:0] period_length;
   logic [31:0] high_length;
   logic        period_valid;
   logic        timeout;

   modport slave (
      input  PWRDWN,
      input  meas_in,
      output period_length,
      output high_length,
      output period_valid,
      output timeout
   );

   modport master (
      output PWRDWN,
      output meas_in,
      input  period_length,
      input  high_length,
      input  period_valid,
      input  timeout
   );
endinterface

// File: rtl/period_count.sv
// Measures period and high time of an asynchronous input in clk cycles.
//   clk   : sampling clock
//   RST_N : asynchronous active-low reset
//   bus   : period_count_if.slave (PWRDWN, meas_in in; results out)
// A rise is detected after a two-flop synchronizer plus a history flop.
// Results are registered and appear the cycle after the detecting rise.
module period_count #(
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic          clk,
   input  logic          RST_N,
   period_count_if.slave bus
);
   localparam int unsigned W = 32;
   localparam logic [W-1:0] TIMEOUT_C = W'(TIMEOUT);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] COUNT = 1'b1;

   logic [0:0]   state_q, state_d;
   logic         s1_q, s2_q, s3_q;
   logic [W-1:0] cnt_q, cnt_d;
   logic [W-1:0] hcnt_q, hcnt_d;
   logic [W-1:0] period_length_q, period_length_d;
   logic [W-1:0] high_length_q, high_length_d;
   logic         period_valid_q, period_valid_d;
   logic         timeout_q, timeout_d;
   logic         rise;
   logic         level;

   assign rise  = s2_q & ~s3_q;
   assign level = s2_q;

   // Synchronizer keeps sampling through power-down so no false edge at exit.
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= bus.meas_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // State and result registers.
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         hcnt_q          <= '0;
         period_length_q <= '0;
         high_length_q   <= '0;
         period_valid_q  <= 1'b0;
         timeout_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         hcnt_q          <= hcnt_d;
         period_length_q <= period_length_d;
         high_length_q   <= high_length_d;
         period_valid_q  <= period_valid_d;
         timeout_q       <= timeout_d;
      end
   end

   // Next-state logic; a rise takes precedence over the timeout check.
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      hcnt_d          = hcnt_q;
      period_length_d = period_length_q;
      high_length_d   = high_length_q;
      period_valid_d  = 1'b0;
      timeout_d       = timeout_q;

      if (bus.PWRDWN) begin
         state_d         = IDLE;
         cnt_d           = '0;
         hcnt_d          = '0;
         period_length_d = '0;
         high_length_d   = '0;
         timeout_d       = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise) begin
                  cnt_d   = W'(1);
                  hcnt_d  = W'(1);
                  state_d = COUNT;
               end
            end
            COUNT: begin
               if (rise) begin
                  period_length_d = cnt_q;
                  high_length_d   = hcnt_q;
                  period_valid_d  = 1'b1;
                  timeout_d       = 1'b0;
                  cnt_d           = W'(1);
                  hcnt_d          = W'(1);
               end else if (cnt_q == TIMEOUT_C) begin
                  period_length_d = '0;
                  high_length_d   = '0;
                  timeout_d       = 1'b1;
                  cnt_d           = '0;
                  hcnt_d          = '0;
                  state_d         = IDLE;
               end else begin
                  cnt_d  = cnt_q + W'(1);
                  hcnt_d = hcnt_q + W'(level);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               hcnt_d  = '0;
            end
         endcase
      end
   end

   assign bus.period_length = period_length_q;
   assign bus.high_length   = high_length_q;
   assign bus.period_valid  = period_valid_q;
   assign bus.timeout       = timeout_q;
endmodule

// File: tb/tb_period_count.sv
// Self-checking bench for period_count: a table of periodic-input scenarios
// plus hand-written timeout, power-down and asynchronous-reset sequences.
// Inputs are driven and outputs sampled on the falling clk edge.
module tb_period_count;
   typedef struct packed {
      logic [31:0] pl;
      logic [31:0] hl;
      logic        v;
      logic        to;
   } out_t;

   typedef struct {
      int sel;   // 0: TIMEOUT=1000 instance, 1: TIMEOUT=16 instance
      int p;     // input period
      int h;     // input high cycles
      int n;     // cycles to run
   } vec_t;

   logic clk;
   logic rst_n_r;
   logic pwrdwn_r;
   logic meas_r;
   out_t oa, ob, o;
   int   checks;
   int   failures;
   vec_t vecs[5];

   period_count_if ifa ();
   period_count_if ifb ();

   assign ifa.PWRDWN  = pwrdwn_r;
   assign ifa.meas_in = meas_r;
   assign ifb.PWRDWN  = pwrdwn_r;
   assign ifb.meas_in = meas_r;

   period_count #(.TIMEOUT(1000)) dut_a (.clk(clk), .RST_N(rst_n_r), .bus(ifa));
   period_count #(.TIMEOUT(16))   dut_b (.clk(clk), .RST_N(rst_n_r), .bus(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // One cycle: sample both DUTs at the falling edge, then drive meas_in.
   task automatic step(input logic m);
      @(negedge clk);
      oa = {ifa.period_length, ifa.high_length, ifa.period_valid, ifa.timeout};
      ob = {ifb.period_length, ifb.high_length, ifb.period_valid, ifb.timeout};
      meas_r = m;
   endtask

   task automatic do_reset();
      rst_n_r  = 1'b0;
      pwrdwn_r = 1'b0;
      meas_r   = 1'b0;
      step(1'b0);
      step(1'b0);
      chk("rst_a_pl", oa.pl, 32'd0);
      chk("rst_a_hl", oa.hl, 32'd0);
      chk("rst_a_v",  32'(oa.v), 32'd0);
      chk("rst_a_to", 32'(oa.to), 32'd0);
      chk("rst_b_pl", ob.pl, 32'd0);
      chk("rst_b_to", 32'(ob.to), 32'd0);
      rst_n_r = 1'b1;
      for (int k = 0; k < 3; k++) step(1'b0);
   endtask

   function automatic logic wave(input int i, input int p, input int h);
      return ((i % p) < h);
   endfunction

   initial begin
      logic ev;
      checks   = 0;
      failures = 0;
      rst_n_r  = 1'b0;
      pwrdwn_r = 1'b0;
      meas_r   = 1'b0;

      vecs[0] = '{sel: 0, p: 10, h: 5, n: 60};
      vecs[1] = '{sel: 1, p: 2,  h: 1, n: 40};
      vecs[2] = '{sel: 1, p: 16, h: 8, n: 80};
      vecs[3] = '{sel: 0, p: 7,  h: 3, n: 50};
      vecs[4] = '{sel: 1, p: 8,  h: 1, n: 45};

      // Periodic scenarios: first rise driven at i=0, results seen 3 cycles
      // after each later rise is driven.
      for (int k = 0; k < 5; k++) begin
         do_reset();
         for (int i = 0; i < vecs[k].n; i++) begin
            step(wave(i, vecs[k].p, vecs[k].h));
            o  = (vecs[k].sel == 0) ? oa : ob;
            ev = (i >= vecs[k].p + 3) && (((i - vecs[k].p - 3) % vecs[k].p) == 0);
            chk($sformatf("vec%0d_valid_i%0d", k, i), 32'(o.v), 32'(ev));
            if (ev) begin
               chk($sformatf("vec%0d_pl_i%0d", k, i), o.pl, 32'(vecs[k].p));
               chk($sformatf("vec%0d_hl_i%0d", k, i), o.hl, 32'(vecs[k].h));
            end else if (i < vecs[k].p + 3) begin
               chk($sformatf("vec%0d_pl0_i%0d", k, i), o.pl, 32'd0);
            end
            chk($sformatf("vec%0d_to_i%0d", k, i), 32'(o.to), 32'd0);
         end
      end

      // Timeout on the TIMEOUT=16 instance: two rises (0, 8), silence, then
      // restart with period 8 from i=30.
      do_reset();
      for (int i = 0; i < 46; i++) begin
         step((i < 4) || (i >= 8 && i < 12) || (i >= 30 && ((i - 30) % 8) < 4));
         if (i == 11) begin
            chk("to_first_v",  32'(ob.v), 32'd1);
            chk("to_first_pl", ob.pl, 32'd8);
            chk("to_first_hl", ob.hl, 32'd4);
         end
         if (i == 26) begin
            chk("to_before_pl", ob.pl, 32'd8);
            chk("to_before_to", 32'(ob.to), 32'd0);
         end
         if (i == 27) begin
            chk("to_hit_to", 32'(ob.to), 32'd1);
            chk("to_hit_pl", ob.pl, 32'd0);
            chk("to_hit_hl", ob.hl, 32'd0);
            chk("to_long_to", 32'(oa.to), 32'd0);
         end
         if (i >= 12 && i <= 40) chk($sformatf("to_nov_i%0d", i), 32'(ob.v), 32'd0);
         if (i >= 27 && i <= 40) chk($sformatf("to_sticky_i%0d", i), 32'(ob.to), 32'd1);
         if (i == 41) begin
            chk("to_clr_to", 32'(ob.to), 32'd0);
            chk("to_clr_v",  32'(ob.v), 32'd1);
            chk("to_clr_pl", ob.pl, 32'd8);
            chk("to_clr_hl", ob.hl, 32'd4);
         end
      end

      // Power-down asserted for 3 cycles mid-period (period 10).
      do_reset();
      for (int i = 0; i < 46; i++) begin
         step(wave(i, 10, 5));
         if (i == 23) chk("pd_pre_v", 32'(oa.v), 32'd1);
         if (i == 25) chk("pd_pre_pl", oa.pl, 32'd10);
         if (i >= 26 && i <= 42) begin
            chk($sformatf("pd_pl_i%0d", i), oa.pl, 32'd0);
            chk($sformatf("pd_hl_i%0d", i), oa.hl, 32'd0);
            chk($sformatf("pd_v_i%0d", i),  32'(oa.v), 32'd0);
         end
         if (i == 43) begin
            chk("pd_post_v",  32'(oa.v), 32'd1);
            chk("pd_post_pl", oa.pl, 32'd10);
            chk("pd_post_hl", oa.hl, 32'd5);
         end
         pwrdwn_r = (i >= 25 && i <= 27);
      end
      pwrdwn_r = 1'b0;

      // Asynchronous reset between clock edges mid-count (period 10).
      do_reset();
      for (int i = 0; i < 46; i++) begin
         step(wave(i, 10, 5));
         if (i == 18) begin
            chk("ar_pre_pl", oa.pl, 32'd10);
            chk("ar_pre_hl", oa.hl, 32'd5);
            #2;
            rst_n_r = 1'b0;
            #1;
            chk("ar_async_pl", ifa.period_length, 32'd0);
            chk("ar_async_hl", ifa.high_length, 32'd0);
         end
         if (i >= 19 && i <= 42) begin
            chk($sformatf("ar_v_i%0d", i),  32'(oa.v), 32'd0);
            chk($sformatf("ar_pl_i%0d", i), oa.pl, 32'd0);
         end
         if (i == 43) begin
            chk("ar_post_v",  32'(oa.v), 32'd1);
            chk("ar_post_pl", oa.pl, 32'd10);
            chk("ar_post_hl", oa.hl, 32'd5);
         end
         if (i == 26) rst_n_r = 1'b1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/period_count.md
Name: period_count

Overview:
- Measures the period and high time of a slow/asynchronous input signal `meas_in`, in cycles of the sampling clock `clk`.
- Produces the 32-bit `period_length` that the stability checker downstream consumes. That checker treats a value of 0 as "no valid period".
- Sits between the monitored clock/signal and the stability checker in the PLL simulation/lock-detect path.

Parameters:
- TIMEOUT, 1000000, max clk cycles without a detected rising edge before the measurement is declared lost; legal range 2 .. 2^32-1.

Ports:
- clk  input  1  sampling clock; all state updates on its rising edge
- RST_N  input  1  asynchronous, active-low reset
- PWRDWN  input  1  synchronous power-down; active high; highest priority after reset
- meas_in  input  1  signal under measurement; asynchronous to clk
- period_length  output  32  last measured period in clk cycles; 0 = no valid measurement
- high_length  output  32  high time, in clk cycles, of the last measured period
- period_valid  output  1  one-cycle pulse when period_length/high_length update with a measurement
- timeout  output  1  sticky flag: no edge seen for TIMEOUT cycles

Behaviour:
- Reset (RST_N=0, async): state IDLE; sync flops, cnt and hcnt cleared; period_length=0, high_length=0, period_valid=0, timeout=0.
- Synchronizer and edge detect:
  - meas_in passes through two flops (s1, s2), then a history flop s3.
  - rise = s2 & ~s3; level = s2.
  - A rising edge on meas_in is detected 2-3 clk cycles after it occurs.
- FSM states:
  - IDLE: waiting for the first rise. On rise: cnt<=1, hcnt<=1, go to COUNT. No output update, no period_valid.
  - COUNT, rise cycle:
    - period_length<=cnt, high_length<=hcnt, period_valid<=1, timeout<=0;
    - cnt<=1, hcnt<=1; stay in COUNT.
  - COUNT, non-rise cycle with cnt==TIMEOUT:
    - period_length<=0, high_length<=0, timeout<=1, period_valid<=0;
    - cnt<=0, hcnt<=0; go to IDLE.
  - COUNT, other cycles: cnt<=cnt+1, hcnt<=hcnt+level.
- Result: for a rise at cycle t and the next rise at t+N, period_length=N and high_length = number of cycles in [t, t+N-1] with level=1.
- period_valid is high for exactly one cycle, coinciding with the new output values. It is 0 on every other cycle, including timeout cycles.
- A rise in the same cycle that cnt==TIMEOUT is recorded as a normal measurement; rise wins over timeout.
- cnt never exceeds TIMEOUT, so no wrap-around is possible. hcnt ≤ cnt always.
- timeout stays 1 while idling after a timeout. It clears on the first valid measurement, i.e. the second rise after the timeout.
- PWRDWN=1 (sampled on clk):
  - state IDLE; cnt, hcnt, period_length, high_length, period_valid and timeout forced to 0;
  - sync flops keep sampling, so no false edge is seen at exit;
  - measurement restarts at the first rise after PWRDWN returns to 0.
- Reset asserted mid-measurement aborts it immediately (async). After release, the first rise is a start edge only.
- Output latency: results are registered and appear the cycle after the detecting rise cycle.

Test Plan:
- Stable 50%-duty input, period 10 clk cycles, TIMEOUT=1000 -> first period_valid at the 2nd detected rise; period_length=10, high_length=5; period_valid pulses every 10 cycles; timeout=0 throughout.
- Minimum period: meas_in toggles every clk cycle via a synchronous source, period 2 -> period_length=2, high_length=1 on each valid pulse.
- TIMEOUT=16, input stops low after a rise -> 17 cycles after that rise: period_length=0, high_length=0, timeout=1, no period_valid. After the input restarts with period 8: timeout stays 1 through the first rise; at the second rise, period_length=8 and timeout=0.
- TIMEOUT=16, input period exactly 16 -> rise coincides with cnt==16; period_length=16, period_valid=1, timeout stays 0.
- PWRDWN pulsed for 3 cycles mid-period (period 10 input) -> all outputs 0 during PWRDWN and after; first period_valid comes at the 2nd rise after PWRDWN deasserts, with period_length=10.
- RST_N asserted asynchronously between clk edges mid-count -> outputs 0 immediately, without waiting for clk. After release, no period_valid until the 2nd detected rise.
